// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//
// Arbitrates the single regfile write port between the in-order pipeline
// writeback stage and a multicycle unit (divider / load-miss return).
// Pipeline writes win by default. Multicycle writes wait in a 2-entry FIFO.
// A starvation counter forces the FIFO head through after STARVE_LIMIT
// consecutive lost arbitrations. Two decode-side query ports return bypass
// data for writes that are still pending (FIFO entries or the registered
// rf_w output).
//
// Write request layout (w_rf_t, 38 bits): {en[37], addr[36:32], wd[31:0]}
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   p_w / p_ready      pipeline write request / accepted this cycle (comb)
//   m_w / m_ready      multicycle write request / FIFO not full (from state)
//   rf_w               registered write to the regfile
//   q_addr1/2          decode query addresses
//   q_hit1/2, q_data1/2  pending-write hit and its data (0 when no hit)
//   m_count            FIFO occupancy 0..2

module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] p_w,
  output logic        p_ready,
  input  logic [37:0] m_w,
  output logic        m_ready,
  output logic [37:0] rf_w,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_hit1,
  output logic        q_hit2,
  output logic [31:0] q_data1,
  output logic [31:0] q_data2,
  output logic [1:0]  m_count
);

  localparam int          EN_BIT   = 37;
  localparam logic [3:0]  SC_LIMIT = 4'(STARVE_LIMIT);

  // request field views
  logic        p_en;
  logic [4:0]  p_addr;
  logic [31:0] p_wd;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_wd;

  assign p_en   = p_w[EN_BIT];
  assign p_addr = p_w[36:32];
  assign p_wd   = p_w[31:0];
  assign m_en   = m_w[EN_BIT];
  assign m_addr = m_w[36:32];
  assign m_wd   = m_w[31:0];

  // FIFO storage and control
  logic [4:0]  fifo_addr_q [2];
  logic [4:0]  fifo_addr_d [2];
  logic [31:0] fifo_wd_q   [2];
  logic [31:0] fifo_wd_d   [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q,  count_d;

  logic [3:0]  sc_q, sc_d;
  logic [37:0] rf_w_q, rf_w_d;

  // arbitration
  logic fifo_ne;
  logic force_m;
  logic grant_m;
  logic grant_p;
  logic push;
  logic pop;

  always_comb begin
    fifo_ne = (count_q != 2'd0);
    force_m = fifo_ne && (sc_q == SC_LIMIT);
    grant_m = force_m || (!p_en && fifo_ne);
    grant_p = !force_m && p_en;

    // m_ready comes from registered count only, so a pop does not free
    // the slot for the multicycle side until the following cycle.
    m_ready = (count_q != 2'd2);
    p_ready = !force_m;

    // Address-0 multicycle requests are accepted (m_ready high) but dropped.
    push = m_en && m_ready && (m_addr != 5'd0);
    pop  = grant_m;
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_wd_d   = fifo_wd_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (push) begin
      fifo_addr_d[wr_ptr_q] = m_addr;
      fifo_wd_d[wr_ptr_q]   = m_wd;
      wr_ptr_d              = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Starvation counter: counts pipeline wins while the FIFO head waits.
  always_comb begin
    sc_d = sc_q;
    if (!fifo_ne || grant_m) begin
      sc_d = 4'd0;
    end else if (grant_p && (sc_q != SC_LIMIT)) begin
      sc_d = sc_q + 4'd1;
    end
  end

  // Output write register: addr/wd hold when nothing real is written, so
  // only en drops on idle cycles and on address-0 pipeline writes.
  always_comb begin
    rf_w_d         = rf_w_q;
    rf_w_d[EN_BIT] = 1'b0;
    if (grant_m) begin
      rf_w_d = {1'b1, fifo_addr_q[rd_ptr_q], fifo_wd_q[rd_ptr_q]};
    end else if (grant_p && (p_addr != 5'd0)) begin
      rf_w_d = {1'b1, p_addr, p_wd};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_addr_q[0] <= '0;
      fifo_addr_q[1] <= '0;
      fifo_wd_q[0]   <= '0;
      fifo_wd_q[1]   <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      sc_q           <= 4'd0;
      rf_w_q         <= '0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_wd_q   <= fifo_wd_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      sc_q        <= sc_d;
      rf_w_q      <= rf_w_d;
    end
  end

  assign rf_w    = rf_w_q;
  assign m_count = count_q;

  // Bypass lookup. With two entries the younger one sits opposite the read
  // pointer; with one entry only the read-pointer slot is live.
  logic young_vld;
  logic old_vld;
  logic young_idx;

  assign young_vld = (count_q == 2'd2);
  assign old_vld   = (count_q != 2'd0);
  assign young_idx = ~rd_ptr_q;

  function automatic logic [32:0] lookup(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 5'd0) begin
      if (young_vld && (fifo_addr_q[young_idx] == a)) begin
        r = {1'b1, fifo_wd_q[young_idx]};
      end else if (old_vld && (fifo_addr_q[rd_ptr_q] == a)) begin
        r = {1'b1, fifo_wd_q[rd_ptr_q]};
      end else if (rf_w_q[EN_BIT] && (rf_w_q[36:32] == a)) begin
        r = {1'b1, rf_w_q[31:0]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {q_hit1, q_data1} = lookup(q_addr1);
    {q_hit2, q_data2} = lookup(q_addr2);
  end

  // Structural invariants of the FIFO control.
  a_count_range : assert property (@(posedge clk) disable iff (reset)
    count_q != 2'd3);
  a_no_push_full : assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == 2'd2)));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset)
    !(pop && (count_q == 2'd0)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic [37:0] p_w;
  logic        p_ready;
  logic [37:0] m_w;
  logic        m_ready;
  logic [37:0] rf_w;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_hit1;
  logic        q_hit2;
  logic [31:0] q_data1;
  logic [31:0] q_data2;
  logic [1:0]  m_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [37:0] exp_q [$];

  typedef struct packed {
    logic [37:0] pw;
    logic [37:0] mw;
    logic        prdy;
    logic        mrdy;
    logic [37:0] rf;
    logic [1:0]  cnt;
    logic [4:0]  qa1;
    logic        qh1;
    logic [31:0] qd1;
    logic [4:0]  qa2;
    logic        qh2;
    logic [31:0] qd2;
  } row_t;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .p_w     (p_w),
    .p_ready (p_ready),
    .m_w     (m_w),
    .m_ready (m_ready),
    .rf_w    (rf_w),
    .q_addr1 (q_addr1),
    .q_addr2 (q_addr2),
    .q_hit1  (q_hit1),
    .q_hit2  (q_hit2),
    .q_data1 (q_data1),
    .q_data2 (q_data2),
    .m_count (m_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [37:0] wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    return {en, a, d};
  endfunction

  function automatic row_t mk(input logic [37:0] pw, input logic [37:0] mw,
                              input logic prdy, input logic mrdy,
                              input logic [37:0] rf, input logic [1:0] cnt,
                              input logic [4:0] qa1, input logic qh1, input logic [31:0] qd1,
                              input logic [4:0] qa2, input logic qh2, input logic [31:0] qd2);
    row_t r;
    r.pw = pw;   r.mw = mw;   r.prdy = prdy; r.mrdy = mrdy;
    r.rf = rf;   r.cnt = cnt;
    r.qa1 = qa1; r.qh1 = qh1; r.qd1 = qd1;
    r.qa2 = qa2; r.qh2 = qh2; r.qd2 = qd2;
    return r;
  endfunction

  // Inputs change 2-3 time units after the rising edge, outputs are sampled
  // mid-cycle, well away from the next edge.
  task automatic drive(input logic [37:0] pw, input logic [37:0] mw);
    p_w = pw;
    m_w = mw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [37:0] got;
    reset = 1'b1;
    drive('0, '0);
    tick();
    tick();
    reset = 1'b0;
    q_addr1 = 5'd5;
    q_addr2 = 5'd7;
    #1;
    got = rf_w;
    n_cmp++; if (got !== 38'd0) begin n_fail++; $display("FAIL reset_rf_w got %h want %h", got, 38'd0); end
    n_cmp++; if (m_count !== 2'd0) begin n_fail++; $display("FAIL reset_m_count got %0d want 0", m_count); end
    n_cmp++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_m_ready got %b want 1", m_ready); end
    n_cmp++; if (q_hit1 !== 1'b0 || q_hit2 !== 1'b0) begin n_fail++; $display("FAIL reset_q_hit got %b%b want 00", q_hit1, q_hit2); end
  endtask

  task automatic test_pipeline_only();
    row_t rows [$];
    logic [37:0] exp;
    for (int i = 0; i < 5; i++)
      rows.push_back(mk(wr(1'b1, 5'd5, 32'hDEADBEEF), '0, 1'b1, 1'b1,
                        wr(1'b1, 5'd5, 32'hDEADBEEF), 2'd0,
                        5'd5, 1'b1, 32'hDEADBEEF, 5'd6, 1'b0, 32'h0));
    rows.push_back(mk(wr(1'b1, 5'd6, 32'h0000_0606), '0, 1'b1, 1'b1,
                      wr(1'b1, 5'd6, 32'h0000_0606), 2'd0,
                      5'd5, 1'b0, 32'h0, 5'd6, 1'b1, 32'h0000_0606));
    rows.push_back(mk('0, '0, 1'b1, 1'b1, wr(1'b0, 5'd6, 32'h0000_0606), 2'd0,
                      5'd5, 1'b0, 32'h0, 5'd6, 1'b0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i].pw, rows[i].mw);
      n_cmp++; if (p_ready !== rows[i].prdy) begin n_fail++; $display("FAIL pipe_p_ready[%0d] got %b want %b", i, p_ready, rows[i].prdy); end
      n_cmp++; if (m_ready !== rows[i].mrdy) begin n_fail++; $display("FAIL pipe_m_ready[%0d] got %b want %b", i, m_ready, rows[i].mrdy); end
      exp_q.push_back(rows[i].rf);
      tick();
      q_addr1 = rows[i].qa1;
      q_addr2 = rows[i].qa2;
      #1;
      exp = exp_q.pop_front();
      n_cmp++; if (rf_w !== exp) begin n_fail++; $display("FAIL pipe_rf_w[%0d] got %h want %h", i, rf_w, exp); end
      n_cmp++; if (m_count !== rows[i].cnt) begin n_fail++; $display("FAIL pipe_m_count[%0d] got %0d want %0d", i, m_count, rows[i].cnt); end
      n_cmp++; if ({q_hit1, q_data1} !== {rows[i].qh1, rows[i].qd1}) begin n_fail++; $display("FAIL pipe_q1[%0d] got %b/%h want %b/%h", i, q_hit1, q_data1, rows[i].qh1, rows[i].qd1); end
      n_cmp++; if ({q_hit2, q_data2} !== {rows[i].qh2, rows[i].qd2}) begin n_fail++; $display("FAIL pipe_q2[%0d] got %b/%h want %b/%h", i, q_hit2, q_data2, rows[i].qh2, rows[i].qd2); end
    end
  endtask

  task automatic test_fifo_fill();
    row_t rows [$];
    logic [37:0] exp;
    logic [37:0] r7, r8, r10;
    r7  = wr(1'b1, 5'd7,  32'h11);
    r8  = wr(1'b1, 5'd8,  32'h22);
    r10 = wr(1'b1, 5'd10, 32'h44);
    rows.push_back(mk(wr(1'b1, 5'd1, 32'h1000), r7,  1'b1, 1'b1, wr(1'b1, 5'd1, 32'h1000), 2'd1, 5'd7,  1'b1, 32'h11,   5'd8, 1'b0, 32'h0));
    rows.push_back(mk(wr(1'b1, 5'd1, 32'h1001), r8,  1'b1, 1'b1, wr(1'b1, 5'd1, 32'h1001), 2'd2, 5'd8,  1'b1, 32'h22,   5'd7, 1'b1, 32'h11));
    rows.push_back(mk(wr(1'b1, 5'd1, 32'h1002), r10, 1'b1, 1'b0, wr(1'b1, 5'd1, 32'h1002), 2'd2, 5'd1,  1'b1, 32'h1002, 5'd10, 1'b0, 32'h0));
    rows.push_back(mk('0, r10, 1'b1, 1'b0, r7,  2'd1, 5'd7,  1'b1, 32'h11, 5'd8, 1'b1, 32'h22));
    rows.push_back(mk('0, r10, 1'b1, 1'b1, r8,  2'd1, 5'd10, 1'b1, 32'h44, 5'd7, 1'b0, 32'h0));
    rows.push_back(mk('0, '0,  1'b1, 1'b1, r10, 2'd0, 5'd8,  1'b0, 32'h0,  5'd10, 1'b1, 32'h44));
    rows.push_back(mk('0, '0,  1'b1, 1'b1, wr(1'b0, 5'd10, 32'h44), 2'd0, 5'd10, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i].pw, rows[i].mw);
      n_cmp++; if (p_ready !== rows[i].prdy) begin n_fail++; $display("FAIL fill_p_ready[%0d] got %b want %b", i, p_ready, rows[i].prdy); end
      n_cmp++; if (m_ready !== rows[i].mrdy) begin n_fail++; $display("FAIL fill_m_ready[%0d] got %b want %b", i, m_ready, rows[i].mrdy); end
      exp_q.push_back(rows[i].rf);
      tick();
      q_addr1 = rows[i].qa1;
      q_addr2 = rows[i].qa2;
      #1;
      exp = exp_q.pop_front();
      n_cmp++; if (rf_w !== exp) begin n_fail++; $display("FAIL fill_rf_w[%0d] got %h want %h", i, rf_w, exp); end
      n_cmp++; if (m_count !== rows[i].cnt) begin n_fail++; $display("FAIL fill_m_count[%0d] got %0d want %0d", i, m_count, rows[i].cnt); end
      n_cmp++; if ({q_hit1, q_data1} !== {rows[i].qh1, rows[i].qd1}) begin n_fail++; $display("FAIL fill_q1[%0d] got %b/%h want %b/%h", i, q_hit1, q_data1, rows[i].qh1, rows[i].qd1); end
      n_cmp++; if ({q_hit2, q_data2} !== {rows[i].qh2, rows[i].qd2}) begin n_fail++; $display("FAIL fill_q2[%0d] got %b/%h want %b/%h", i, q_hit2, q_data2, rows[i].qh2, rows[i].qd2); end
    end
  endtask

  task automatic test_starvation();
    row_t rows [$];
    logic [37:0] exp;
    logic [37:0] r9;
    r9 = wr(1'b1, 5'd9, 32'h33);
    // r9 enqueues while the FIFO is still empty, so that pipeline win does
    // not count; the four wins after it do.
    rows.push_back(mk(wr(1'b1, 5'd2, 32'h200), r9, 1'b1, 1'b1, wr(1'b1, 5'd2, 32'h200), 2'd1, 5'd9, 1'b1, 32'h33, 5'd2, 1'b1, 32'h200));
    for (int k = 1; k <= 4; k++)
      rows.push_back(mk(wr(1'b1, 5'd2, 32'h200 + 32'(k)), '0, 1'b1, 1'b1,
                        wr(1'b1, 5'd2, 32'h200 + 32'(k)), 2'd1,
                        5'd2, 1'b1, 32'h200 + 32'(k), 5'd9, 1'b1, 32'h33));
    rows.push_back(mk(wr(1'b1, 5'd2, 32'h205), '0, 1'b0, 1'b1, r9, 2'd0, 5'd9, 1'b1, 32'h33, 5'd2, 1'b0, 32'h0));
    rows.push_back(mk(wr(1'b1, 5'd2, 32'h205), '0, 1'b1, 1'b1, wr(1'b1, 5'd2, 32'h205), 2'd0, 5'd9, 1'b0, 32'h0, 5'd2, 1'b1, 32'h205));
    rows.push_back(mk(wr(1'b1, 5'd2, 32'h206), '0, 1'b1, 1'b1, wr(1'b1, 5'd2, 32'h206), 2'd0, 5'd2, 1'b1, 32'h206, 5'd9, 1'b0, 32'h0));
    rows.push_back(mk('0, '0, 1'b1, 1'b1, wr(1'b0, 5'd2, 32'h206), 2'd0, 5'd2, 1'b0, 32'h0, 5'd9, 1'b0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i].pw, rows[i].mw);
      n_cmp++; if (p_ready !== rows[i].prdy) begin n_fail++; $display("FAIL starve_p_ready[%0d] got %b want %b", i, p_ready, rows[i].prdy); end
      n_cmp++; if (m_ready !== rows[i].mrdy) begin n_fail++; $display("FAIL starve_m_ready[%0d] got %b want %b", i, m_ready, rows[i].mrdy); end
      exp_q.push_back(rows[i].rf);
      tick();
      q_addr1 = rows[i].qa1;
      q_addr2 = rows[i].qa2;
      #1;
      exp = exp_q.pop_front();
      n_cmp++; if (rf_w !== exp) begin n_fail++; $display("FAIL starve_rf_w[%0d] got %h want %h", i, rf_w, exp); end
      n_cmp++; if (m_count !== rows[i].cnt) begin n_fail++; $display("FAIL starve_m_count[%0d] got %0d want %0d", i, m_count, rows[i].cnt); end
      n_cmp++; if ({q_hit1, q_data1} !== {rows[i].qh1, rows[i].qd1}) begin n_fail++; $display("FAIL starve_q1[%0d] got %b/%h want %b/%h", i, q_hit1, q_data1, rows[i].qh1, rows[i].qd1); end
      n_cmp++; if ({q_hit2, q_data2} !== {rows[i].qh2, rows[i].qd2}) begin n_fail++; $display("FAIL starve_q2[%0d] got %b/%h want %b/%h", i, q_hit2, q_data2, rows[i].qh2, rows[i].qd2); end
    end
  endtask

  task automatic test_query_bypass();
    row_t rows [$];
    logic [37:0] exp;
    rows.push_back(mk(wr(1'b1, 5'd6, 32'h600), wr(1'b1, 5'd3, 32'hA), 1'b1, 1'b1, wr(1'b1, 5'd6, 32'h600), 2'd1, 5'd3, 1'b1, 32'hA, 5'd6, 1'b1, 32'h600));
    rows.push_back(mk(wr(1'b1, 5'd6, 32'h601), wr(1'b1, 5'd3, 32'hB), 1'b1, 1'b1, wr(1'b1, 5'd6, 32'h601), 2'd2, 5'd3, 1'b1, 32'hB, 5'd0, 1'b0, 32'h0));
    // FIFO {A older, B younger}, rf_w = r3/0xC: youngest FIFO entry wins.
    rows.push_back(mk(wr(1'b1, 5'd3, 32'hC), '0, 1'b1, 1'b0, wr(1'b1, 5'd3, 32'hC), 2'd2, 5'd3, 1'b1, 32'hB, 5'd0, 1'b0, 32'h0));
    rows.push_back(mk('0, '0, 1'b1, 1'b0, wr(1'b1, 5'd3, 32'hA), 2'd1, 5'd3, 1'b1, 32'hB, 5'd6, 1'b0, 32'h0));
    rows.push_back(mk('0, '0, 1'b1, 1'b1, wr(1'b1, 5'd3, 32'hB), 2'd0, 5'd3, 1'b1, 32'hB, 5'd0, 1'b0, 32'h0));
    rows.push_back(mk('0, '0, 1'b1, 1'b1, wr(1'b0, 5'd3, 32'hB), 2'd0, 5'd3, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0));
    foreach (rows[i]) begin
      drive(rows[i].pw, rows[i].mw);
      n_cmp++; if (p_ready !== rows[i].prdy) begin n_fail++; $display("FAIL query_p_ready[%0d] got %b want %b", i, p_ready, rows[i].prdy); end
      n_cmp++; if (m_ready !== rows[i].mrdy) begin n_fail++; $display("FAIL query_m_ready[%0d] got %b want %b", i, m_ready, rows[i].mrdy); end
      exp_q.push_back(rows[i].rf);
      tick();
      q_addr1 = rows[i].qa1;
      q_addr2 = rows[i].qa2;
      #1;
      exp = exp_q.pop_front();
      n_cmp++; if (rf_w !== exp) begin n_fail++; $display("FAIL query_rf_w[%0d] got %h want %h", i, rf_w, exp); end
      n_cmp++; if (m_count !== rows[i].cnt) begin n_fail++; $display("FAIL query_m_count[%0d] got %0d want %0d", i, m_count, rows[i].cnt); end
      n_cmp++; if ({q_hit1, q_data1} !== {rows[i].qh1, rows[i].qd1}) begin n_fail++; $display("FAIL query_q1[%0d] got %b/%h want %b/%h", i, q_hit1, q_data1, rows[i].qh1, rows[i].qd1); end
      n_cmp++; if ({q_hit2, q_data2} !== {rows[i].qh2, rows[i].qd2}) begin n_fail++; $display("FAIL query_q2[%0d] got %b/%h want %b/%h", i, q_hit2, q_data2, rows[i].qh2, rows[i].qd2); end
    end
  endtask

  task automatic test_zero_addr();
    logic [37:0] exp;
    drive('0, wr(1'b1, 5'd0, 32'h55));
    n_cmp++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL zero_m_ready_pre got %b want 1", m_ready); end
    exp_q.push_back(wr(1'b0, 5'd3, 32'hB));
    tick();
    exp = exp_q.pop_front();
    n_cmp++; if (rf_w !== exp) begin n_fail++; $display("FAIL zero_m_rf_w got %h want %h", rf_w, exp); end
    n_cmp++; if (m_count !== 2'd0) begin n_fail++; $display("FAIL zero_m_count got %0d want 0", m_count); end
    n_cmp++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL zero_m_ready_post got %b want 1", m_ready); end

    drive(wr(1'b1, 5'd0, 32'h66), '0);
    n_cmp++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL zero_p_ready got %b want 1", p_ready); end
    tick();
    q_addr1 = 5'd0;
    #1;
    n_cmp++; if (rf_w[37] !== 1'b0) begin n_fail++; $display("FAIL zero_p_rf_en got %b want 0", rf_w[37]); end
    n_cmp++; if (q_hit1 !== 1'b0) begin n_fail++; $display("FAIL zero_q_hit got %b want 0", q_hit1); end

    drive(wr(1'b1, 5'd4, 32'h4444_4444), '0);
    exp_q.push_back(wr(1'b1, 5'd4, 32'h4444_4444));
    tick();
    exp = exp_q.pop_front();
    n_cmp++; if (rf_w !== exp) begin n_fail++; $display("FAIL zero_resume_rf_w got %h want %h", rf_w, exp); end
  endtask

  task automatic test_reset_mid();
    row_t rows [$];
    logic [37:0] exp;
    // Leaves the FIFO full (r11, r12) with sc at 3.
    rows.push_back(mk(wr(1'b1, 5'd1, 32'h900), wr(1'b1, 5'd11, 32'h77), 1'b1, 1'b1, wr(1'b1, 5'd1, 32'h900), 2'd1, 5'd11, 1'b1, 32'h77, 5'd12, 1'b0, 32'h0));
    rows.push_back(mk(wr(1'b1, 5'd1, 32'h901), wr(1'b1, 5'd12, 32'h88), 1'b1, 1'b1, wr(1'b1, 5'd1, 32'h901), 2'd2, 5'd11, 1'b1, 32'h77, 5'd12, 1'b1, 32'h88));
    rows.push_back(mk(wr(1'b1, 5'd1, 32'h902), '0, 1'b1, 1'b0, wr(1'b1, 5'd1, 32'h902), 2'd2, 5'd11, 1'b1, 32'h77, 5'd12, 1'b1, 32'h88));
    rows.push_back(mk(wr(1'b1, 5'd1, 32'h903), '0, 1'b1, 1'b0, wr(1'b1, 5'd1, 32'h903), 2'd2, 5'd11, 1'b1, 32'h77, 5'd1, 1'b1, 32'h903));
    foreach (rows[i]) begin
      drive(rows[i].pw, rows[i].mw);
      n_cmp++; if (p_ready !== rows[i].prdy) begin n_fail++; $display("FAIL rstmid_p_ready[%0d] got %b want %b", i, p_ready, rows[i].prdy); end
      n_cmp++; if (m_ready !== rows[i].mrdy) begin n_fail++; $display("FAIL rstmid_m_ready[%0d] got %b want %b", i, m_ready, rows[i].mrdy); end
      exp_q.push_back(rows[i].rf);
      tick();
      q_addr1 = rows[i].qa1;
      q_addr2 = rows[i].qa2;
      #1;
      exp = exp_q.pop_front();
      n_cmp++; if (rf_w !== exp) begin n_fail++; $display("FAIL rstmid_rf_w[%0d] got %h want %h", i, rf_w, exp); end
      n_cmp++; if (m_count !== rows[i].cnt) begin n_fail++; $display("FAIL rstmid_m_count[%0d] got %0d want %0d", i, m_count, rows[i].cnt); end
      n_cmp++; if ({q_hit1, q_data1} !== {rows[i].qh1, rows[i].qd1}) begin n_fail++; $display("FAIL rstmid_q1[%0d] got %b/%h want %b/%h", i, q_hit1, q_data1, rows[i].qh1, rows[i].qd1); end
      n_cmp++; if ({q_hit2, q_data2} !== {rows[i].qh2, rows[i].qd2}) begin n_fail++; $display("FAIL rstmid_q2[%0d] got %b/%h want %b/%h", i, q_hit2, q_data2, rows[i].qh2, rows[i].qd2); end
    end

    reset = 1'b1;
    drive(wr(1'b1, 5'd1, 32'h904), '0);
    tick();
    reset = 1'b0;
    drive('0, '0);
    q_addr1 = 5'd11;
    q_addr2 = 5'd12;
    #1;
    n_cmp++; if (m_count !== 2'd0) begin n_fail++; $display("FAIL rstmid_count_after got %0d want 0", m_count); end
    n_cmp++; if (rf_w !== 38'd0) begin n_fail++; $display("FAIL rstmid_rf_w_after got %h want 0", rf_w); end
    n_cmp++; if (q_hit1 !== 1'b0 || q_hit2 !== 1'b0) begin n_fail++; $display("FAIL rstmid_hits got %b%b want 00", q_hit1, q_hit2); end
    n_cmp++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_m_ready got %b want 1", m_ready); end

    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (rf_w[37] !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost[%0d] got en=%b addr=%0d want en=0", k, rf_w[37], rf_w[36:32]); end
      n_cmp++; if (m_count !== 2'd0) begin n_fail++; $display("FAIL rstmid_idle_count[%0d] got %0d want 0", k, m_count); end
    end
  endtask

  initial begin
    reset   = 1'b1;
    p_w     = '0;
    m_w     = '0;
    q_addr1 = '0;
    q_addr2 = '0;

    test_reset();
    test_pipeline_only();
    test_fifo_fill();
    test_starvation();
    test_query_bypass();
    test_zero_addr();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single regfile write port (`w_rf_t`) between the in-order pipeline writeback stage and a multicycle unit (divider / load-miss return). Pipeline writes have priority. Multicycle writes queue in a 2-entry FIFO. A starvation counter forces the FIFO head through after a bounded wait. Decode-side query ports expose not-yet-committed writes as bypass data. The block sits between writeback and the regfile's `writeback` modport.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations after which the multicycle head wins; legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `p_w`  in  w_rf_t (38)  pipeline write request; valid when `p_w.en`.
- `p_ready`  out  1  pipeline request accepted this cycle; combinational.
- `m_w`  in  w_rf_t (38)  multicycle write request; valid when `m_w.en`.
- `m_ready`  out  1  FIFO not full; registered-state based.
- `rf_w`  out  w_rf_t (38)  registered write to regfile; reset 0.
- `q_addr1`, `q_addr2`  in  5  decode query addresses.
- `q_hit1`, `q_hit2`  out  1  a pending write to the queried address exists.
- `q_data1`, `q_data2`  out  32  data of the highest-priority pending write; 0 when no hit.
- `m_count`  out  2  FIFO occupancy 0..2; reset 0.

## Operation
- FIFO: 2 entries, each {addr, wd}, with rd/wr pointers and a count.
  - Enqueue when `m_w.en && m_ready && m_w.addr != 0`.
  - When `m_w.en && m_ready && m_w.addr == 0`, the request is accepted and discarded.
- `m_ready = (m_count != 2)`. It does not rise in the cycle of a pop; it rises the cycle after.
- Starvation counter `sc` (4 bits):
  - Increments when the FIFO is non-empty and the pipeline wins the port.
  - Clears on an FIFO grant or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- Arbitration, each cycle, in priority order:
  1. `sc == STARVE_LIMIT` and FIFO non-empty: grant FIFO head, `p_ready = 0`.
  2. Otherwise `p_w.en`: grant pipeline, `p_ready = 1`.
  3. Otherwise FIFO non-empty: grant FIFO head.
  4. Otherwise idle.
- `p_ready = 1` whenever rule 1 does not hold, including when `p_w.en = 0`.
- A granted pipeline write with `addr == 0` is accepted (`p_ready = 1`) but produces `rf_w.en = 0`. It still counts as a pipeline win for `sc`.
- On grant, next cycle: `rf_w <= {1, addr, wd}`. On idle: `rf_w.en <= 0`; `rf_w.addr` and `rf_w.wd` hold.
- FIFO pop occurs on the head grant. Push and pop may occur in the same cycle when count is 1; count stays 1.
- Query hit priority, per port:
  1. Youngest FIFO entry with matching addr.
  2. Older FIFO entry.
  3. `rf_w` when `rf_w.en`.
- Query address 0 never hits. Incoming `p_w`/`m_w` of the current cycle are not visible to queries.
- Same-address writes from `p_w` and `m_w` are never outstanding together; the upstream scoreboard guarantees this.

## Timing
- Pipeline: accepted at cycle t → `rf_w` valid at t+1. Latency 1 under all conditions except a starvation override, where the pipeline must hold `p_w`.
- Multicycle: enqueued at t → earliest grant at t+1 → `rf_w` at t+2.
- Worst-case FIFO-head wait: `STARVE_LIMIT` pipeline wins plus the forced cycle.
- Starvation example with limit 4: FIFO head waits while the pipeline writes at t..t+3; forced grant at t+4; `p_ready = 0` at t+4.
- Query outputs are combinational from registered state (FIFO, `rf_w`), with no input-to-output path except `q_addr*`.
- Reset in any cycle:
  - Next cycle: FIFO empty, `m_count = 0`, `sc = 0`, `rf_w = 0`, all `q_hit* = 0`.
  - Pending writes are discarded.
  - `m_ready` reads 1 from the first post-reset cycle.

## Test plan
- Pipeline only: `p_w = {1, 5, 0xDEADBEEF}` each cycle → `rf_w = {1, 5, 0xDEADBEEF}` one cycle later; `p_ready` constantly 1; `m_count = 0`.
- FIFO fill/backpressure:
  - Stimulus: `p_w.en` held 1. Push m writes (r7 = 0x11, r8 = 0x22), then a third m write.
  - Required: `m_count = 2`, `m_ready = 0`, third write held off.
  - Release `p_w.en = 0` → r7 then r8 on `rf_w` on consecutive cycles; `m_ready` high the cycle after the first pop.
- Starvation with `STARVE_LIMIT = 4`: FIFO holds r9 = 0x33 and the pipeline writes continuously → exactly 4 pipeline writes, then `p_ready = 0` for one cycle, then `rf_w = {1, 9, 0x33}`, then pipeline writes resume.
- Query bypass:
  - FIFO holds r3 = 0xA (older) and r3 = 0xB (younger); `rf_w = {1, 3, 0xC}`.
  - `q_addr1 = 3` → `q_hit1 = 1`, `q_data1 = 0xB`.
  - `q_addr2 = 0` → `q_hit2 = 0`, `q_data2 = 0`.
- Zero-address drop: `m_w = {1, 0, 0x55}` → `m_ready` stays 1, `m_count` unchanged; `p_w = {1, 0, 0x66}` → `rf_w.en = 0` next cycle.
- Reset mid-operation: assert `reset` with `m_count = 2`, `sc = 3` → next cycle `m_count = 0`, `rf_w.en = 0`, no hits, and queued writes are never emitted.
